// File: rtl/n_term_frame_relay.sv
// North-terminating tile frame relay: retimes FrameData/FrameStrobe up the
// column, captures the tile's local configuration frames on strobe rising
// edges, and tracks column configuration progress.
module n_term_frame_relay #(
    parameter int unsigned FRAME_BITS   = 32,
    parameter int unsigned FRAMES       = 20,
    parameter int unsigned PIPE_STAGES  = 1,
    parameter int unsigned LOCAL_FRAMES = 2,
    parameter int unsigned CFG_BASE     = 0
) (
    input  logic                               UserCLK,
    input  logic                               UserRSTn,
    input  logic [FRAME_BITS-1:0]              FrameData,
    input  logic [FRAMES-1:0]                  FrameStrobe,
    output logic [FRAME_BITS-1:0]              FrameData_O,
    output logic [FRAMES-1:0]                  FrameStrobe_O,
    output logic [LOCAL_FRAMES*FRAME_BITS-1:0] ConfigBits,
    output logic                               CfgValid,
    output logic [7:0]                         FrameCount,
    output logic                               StrobeErr
);

    typedef enum logic [1:0] {
        StUnconfig,
        StLoading,
        StConfigured
    } state_e;

    state_e                            state_q, state_d;
    logic [FRAMES-1:0]                 prev_strobe_q;
    logic [FRAMES-1:0]                 rise;
    logic [LOCAL_FRAMES-1:0]           local_rise;
    logic                              one_hot;
    logic                              multi;
    logic [LOCAL_FRAMES-1:0]           written_q, written_d;
    logic [LOCAL_FRAMES*FRAME_BITS-1:0] cfg_q, cfg_d;
    logic                              cfg_valid_q, cfg_valid_d;
    logic [7:0]                        count_q, count_d;
    logic                              err_q, err_d;

    // Relay path: data and strobe share the same delay so they stay aligned.
    if (PIPE_STAGES == 0) begin : g_wire
        assign FrameData_O   = FrameData;
        assign FrameStrobe_O = FrameStrobe;
    end else begin : g_pipe
        logic [FRAME_BITS-1:0] data_q   [PIPE_STAGES];
        logic [FRAMES-1:0]     strobe_q [PIPE_STAGES];

        // Shift register of retiming stages.
        always_ff @(posedge UserCLK or negedge UserRSTn) begin
            if (!UserRSTn) begin
                for (int i = 0; i < int'(PIPE_STAGES); i++) begin
                    data_q[i]   <= '0;
                    strobe_q[i] <= '0;
                end
            end else begin
                data_q[0]   <= FrameData;
                strobe_q[0] <= FrameStrobe;
                for (int i = 1; i < int'(PIPE_STAGES); i++) begin
                    data_q[i]   <= data_q[i-1];
                    strobe_q[i] <= strobe_q[i-1];
                end
            end
        end

        assign FrameData_O   = data_q[PIPE_STAGES-1];
        assign FrameStrobe_O = strobe_q[PIPE_STAGES-1];
    end

    // Edge detection works on the undelayed strobes.
    assign rise       = FrameStrobe & ~prev_strobe_q;
    assign local_rise = rise[CFG_BASE +: LOCAL_FRAMES];
    assign one_hot    = (local_rise != '0) &&
                        ((local_rise & (local_rise - LOCAL_FRAMES'(1))) == '0);
    assign multi      = (local_rise != '0) && !one_hot;

    // Next-state: capture, collision flag, progress FSM and event counter.
    always_comb begin
        cfg_d     = cfg_q;
        written_d = written_q;
        err_d     = err_q;
        count_d   = count_q;
        state_d   = state_q;

        if (one_hot) begin
            for (int k = 0; k < int'(LOCAL_FRAMES); k++) begin
                if (local_rise[k]) begin
                    cfg_d[k*FRAME_BITS +: FRAME_BITS] = FrameData;
                end
            end
            written_d = written_q | local_rise;
        end
        if (multi) begin
            err_d = 1'b1;
        end

        // One increment per cycle regardless of how many strobes rose.
        if ((rise != '0) && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end

        case (state_q)
            StUnconfig: begin
                if (one_hot) begin
                    state_d = (&written_d) ? StConfigured : StLoading;
                end
            end
            StLoading: begin
                if (&written_d) begin
                    state_d = StConfigured;
                end
            end
            StConfigured: state_d = StConfigured;
            default:      state_d = StUnconfig;
        endcase

        cfg_valid_d = (state_d == StConfigured);
    end

    // State registers; reset discards every captured frame.
    always_ff @(posedge UserCLK or negedge UserRSTn) begin
        if (!UserRSTn) begin
            state_q       <= StUnconfig;
            prev_strobe_q <= '0;
            written_q     <= '0;
            cfg_q         <= '0;
            cfg_valid_q   <= 1'b0;
            count_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_strobe_q <= FrameStrobe;
            written_q     <= written_d;
            cfg_q         <= cfg_d;
            cfg_valid_q   <= cfg_valid_d;
            count_q       <= count_d;
            err_q         <= err_d;
        end
    end

    assign ConfigBits = cfg_q;
    assign CfgValid   = cfg_valid_q;
    assign FrameCount = count_q;
    assign StrobeErr  = err_q;

endmodule

// File: tb/tb_n_term_frame_relay.sv
// Self-checking bench for n_term_frame_relay: directed vector table,
// randomized streams against a behavioural model, and corner sequences.
module tb_n_term_frame_relay;

    localparam int FB = 32;
    localparam int FR = 20;
    localparam int LF = 2;

    logic          UserCLK = 1'b0;
    logic          UserRSTn;
    logic [FB-1:0] FrameData;
    logic [FR-1:0] FrameStrobe;

    logic [FB-1:0]    d1_do, d0_do, d3_do;
    logic [FR-1:0]    d1_so, d0_so, d3_so;
    logic [LF*FB-1:0] d1_cfg, d0_cfg, d3_cfg;
    logic             d1_v, d0_v, d3_v;
    logic [7:0]       d1_cnt, d0_cnt, d3_cnt;
    logic             d1_err, d0_err, d3_err;

    always #5 UserCLK = ~UserCLK;

    n_term_frame_relay dut (
        .UserCLK(UserCLK), .UserRSTn(UserRSTn), .FrameData(FrameData),
        .FrameStrobe(FrameStrobe), .FrameData_O(d1_do), .FrameStrobe_O(d1_so),
        .ConfigBits(d1_cfg), .CfgValid(d1_v), .FrameCount(d1_cnt), .StrobeErr(d1_err)
    );

    n_term_frame_relay #(.PIPE_STAGES(0)) dut_p0 (
        .UserCLK(UserCLK), .UserRSTn(UserRSTn), .FrameData(FrameData),
        .FrameStrobe(FrameStrobe), .FrameData_O(d0_do), .FrameStrobe_O(d0_so),
        .ConfigBits(d0_cfg), .CfgValid(d0_v), .FrameCount(d0_cnt), .StrobeErr(d0_err)
    );

    n_term_frame_relay #(.PIPE_STAGES(3)) dut_p3 (
        .UserCLK(UserCLK), .UserRSTn(UserRSTn), .FrameData(FrameData),
        .FrameStrobe(FrameStrobe), .FrameData_O(d3_do), .FrameStrobe_O(d3_so),
        .ConfigBits(d3_cfg), .CfgValid(d3_v), .FrameCount(d3_cnt), .StrobeErr(d3_err)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [FR-1:0]    m_prev;
    logic [FB-1:0]    m_frame [LF];
    bit               m_seen  [LF];
    int               m_count;
    bit               m_err;
    logic [FB+FR-1:0] hist [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LF*FB-1:0] m_cfg();
        logic [LF*FB-1:0] v;
        for (int k = 0; k < LF; k++) v[k*FB +: FB] = m_frame[k];
        return v;
    endfunction

    function automatic bit m_valid();
        bit all = 1'b1;
        for (int k = 0; k < LF; k++) all &= m_seen[k];
        return all;
    endfunction

    function automatic logic [FB+FR-1:0] delayed(input int n);
        if (hist.size() >= n) return hist[n-1];
        return '0;
    endfunction

    task automatic model_clear();
        m_prev  = '0;
        m_count = 0;
        m_err   = 1'b0;
        for (int k = 0; k < LF; k++) begin
            m_frame[k] = '0;
            m_seen[k]  = 1'b0;
        end
        hist.delete();
    endtask

    // Apply one clock's worth of inputs to the model.
    task automatic model_step(input logic [FB-1:0] d, input logic [FR-1:0] s);
        logic [FR-1:0] r;
        int n;
        int which;
        r      = s & ~m_prev;
        m_prev = s;
        if (r != 0 && m_count < 255) m_count++;
        n = 0;
        which = 0;
        for (int k = 0; k < LF; k++) begin
            if (r[k]) begin
                n++;
                which = k;
            end
        end
        if (n == 1) begin
            m_frame[which] = d;
            m_seen[which]  = 1'b1;
        end else if (n > 1) begin
            m_err = 1'b1;
        end
        hist.push_front({d, s});
        if (hist.size() > 4) void'(hist.pop_back());
    endtask

    task automatic model_check();
        logic [FB+FR-1:0] e1, e3;
        e1 = delayed(1);
        e3 = delayed(3);
        chk("p1_data", 64'(d1_do), 64'(e1[FR +: FB]));
        chk("p1_strobe", 64'(d1_so), 64'(e1[FR-1:0]));
        chk("p0_data", 64'(d0_do), 64'(FrameData));
        chk("p0_strobe", 64'(d0_so), 64'(FrameStrobe));
        chk("p3_data", 64'(d3_do), 64'(e3[FR +: FB]));
        chk("p3_strobe", 64'(d3_so), 64'(e3[FR-1:0]));
        chk("cfg", 64'(d1_cfg), 64'(m_cfg()));
        chk("valid", 64'(d1_v), 64'(m_valid()));
        chk("count", 64'(d1_cnt), 64'(m_count));
        chk("err", 64'(d1_err), 64'(m_err));
        chk("p0_cfg", 64'(d0_cfg), 64'(m_cfg()));
        chk("p3_count", 64'(d3_cnt), 64'(m_count));
        chk("p3_valid", 64'(d3_v), 64'(m_valid()));
        chk("p0_err", 64'(d0_err), 64'(m_err));
    endtask

    // Drive inputs mid-cycle, let one rising edge sample them, check at edge+1.
    task automatic drive(input logic [FB-1:0] d, input logic [FR-1:0] s);
        @(negedge UserCLK);
        FrameData   = d;
        FrameStrobe = s;
        @(posedge UserCLK);
        model_step(d, s);
        #1;
        model_check();
    endtask

    // Asynchronous reset pulse between edges; called just after a check point.
    task automatic do_reset();
        UserRSTn    = 1'b0;
        FrameData   = '0;
        FrameStrobe = '0;
        model_clear();
        #3;
        UserRSTn = 1'b1;
    endtask

    typedef struct {
        logic [FB-1:0]    d;
        logic [FR-1:0]    s;
        logic [LF*FB-1:0] cfg;
        logic             v;
        logic [7:0]       cnt;
        logic             err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{32'hDEADBEEF, 20'h00001, 64'h00000000_DEADBEEF, 1'b0, 8'd1, 1'b0};
        vecs[1]  = '{32'h00000000, 20'h00000, 64'h00000000_DEADBEEF, 1'b0, 8'd1, 1'b0};
        vecs[2]  = '{32'h12345678, 20'h00002, 64'h12345678_DEADBEEF, 1'b1, 8'd2, 1'b0};
        vecs[3]  = '{32'hAAAAAAAA, 20'h00002, 64'h12345678_DEADBEEF, 1'b1, 8'd2, 1'b0};
        vecs[4]  = '{32'hBBBBBBBB, 20'h00002, 64'h12345678_DEADBEEF, 1'b1, 8'd2, 1'b0};
        vecs[5]  = '{32'hCCCCCCCC, 20'h00002, 64'h12345678_DEADBEEF, 1'b1, 8'd2, 1'b0};
        vecs[6]  = '{32'hDDDDDDDD, 20'h00002, 64'h12345678_DEADBEEF, 1'b1, 8'd2, 1'b0};
        vecs[7]  = '{32'h00000000, 20'h00000, 64'h12345678_DEADBEEF, 1'b1, 8'd2, 1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 20'h00003, 64'h12345678_DEADBEEF, 1'b1, 8'd3, 1'b1};
        vecs[9]  = '{32'h00000000, 20'h00000, 64'h12345678_DEADBEEF, 1'b1, 8'd3, 1'b1};
        vecs[10] = '{32'h55555555, 20'h80000, 64'h12345678_DEADBEEF, 1'b1, 8'd4, 1'b1};
        vecs[11] = '{32'h00000000, 20'h00000, 64'h12345678_DEADBEEF, 1'b1, 8'd4, 1'b1};

        // Reset state.
        UserRSTn    = 1'b0;
        FrameData   = 32'hFFFFFFFF;
        FrameStrobe = '0;
        model_clear();
        #2;
        chk("rst_data", 64'(d1_do), 64'h0);
        chk("rst_strobe", 64'(d1_so), 64'h0);
        chk("rst_cfg", 64'(d1_cfg), 64'h0);
        chk("rst_valid", 64'(d1_v), 64'h0);
        chk("rst_count", 64'(d1_cnt), 64'h0);
        chk("rst_err", 64'(d1_err), 64'h0);
        chk("rst_p0_passthru", 64'(d0_do), 64'hFFFFFFFF);
        #20;
        FrameData = '0;
        UserRSTn  = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].d, vecs[i].s);
            chk("tbl_data", 64'(d1_do), 64'(vecs[i].d));
            chk("tbl_strobe", 64'(d1_so), 64'(vecs[i].s));
            chk("tbl_cfg", 64'(d1_cfg), 64'(vecs[i].cfg));
            chk("tbl_valid", 64'(d1_v), 64'(vecs[i].v));
            chk("tbl_count", 64'(d1_cnt), 64'(vecs[i].cnt));
            chk("tbl_err", 64'(d1_err), 64'(vecs[i].err));
        end

        // Randomized streams against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [FR-1:0] s;
            s = FR'($urandom & $urandom);
            if ($urandom_range(0, 2) == 0) s = '0;
            drive($urandom, s);
        end

        // Counter saturation with non-local strobes only.
        do_reset();
        drive(32'h11111111, 20'h00001);
        drive(32'h0, 20'h0);
        drive(32'h22222222, 20'h00002);
        drive(32'h0, 20'h0);
        for (int i = 0; i < 300; i++) begin
            drive($urandom, 20'h80000);
            drive($urandom, 20'h00000);
        end
        chk("sat_count", 64'(d1_cnt), 64'd255);
        chk("sat_cfg", 64'(d1_cfg), 64'h22222222_11111111);
        chk("sat_valid", 64'(d1_v), 64'h1);
        chk("sat_err", 64'(d1_err), 64'h0);

        // Reset between edges while loading with the strobe held.
        do_reset();
        drive(32'hCAFEF00D, 20'h00001);
        chk("mid_cfg_pre", 64'(d1_cfg), 64'h00000000_CAFEF00D);
        #2;
        UserRSTn = 1'b0;
        #1;
        chk("mid_rst_data", 64'(d1_do), 64'h0);
        chk("mid_rst_strobe", 64'(d1_so), 64'h0);
        chk("mid_rst_cfg", 64'(d1_cfg), 64'h0);
        chk("mid_rst_valid", 64'(d1_v), 64'h0);
        chk("mid_rst_count", 64'(d1_cnt), 64'h0);
        chk("mid_rst_p3_strobe", 64'(d3_so), 64'h0);
        model_clear();
        UserRSTn = 1'b1;
        drive(32'h0BADC0DE, 20'h00001);
        chk("mid_recapture", 64'(d1_cfg), 64'h00000000_0BADC0DE);
        chk("mid_count", 64'(d1_cnt), 64'd1);
        chk("mid_valid", 64'(d1_v), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
